// File: rtl/sattn_pkg.sv
// Shared definitions for the sparse-attention accelerator register file: register
// offsets, command opcodes, the MMIO host state encoding and the latched descriptor.
package sattn_pkg;

  localparam logic [7:0] REG_Q_BASE    = 8'h00;
  localparam logic [7:0] REG_K_BASE    = 8'h08;
  localparam logic [7:0] REG_V_BASE    = 8'h10;
  localparam logic [7:0] REG_O_BASE    = 8'h18;
  localparam logic [7:0] REG_IDX_BASE  = 8'h20;
  localparam logic [7:0] REG_STRD_BASE = 8'h28;
  localparam logic [7:0] REG_M_ROWS    = 8'h30;
  localparam logic [7:0] REG_HEAD_D    = 8'h38;
  localparam logic [7:0] REG_BLOCK_SZ  = 8'h40;
  localparam logic [7:0] REG_K_BLOCKS  = 8'h48;
  localparam logic [7:0] REG_S_TOKENS  = 8'h50;
  localparam logic [7:0] REG_SCALE_FP  = 8'h58;
  localparam logic [7:0] REG_CMD       = 8'h60;
  localparam logic [7:0] REG_SUM       = 8'h68;
  localparam logic [7:0] REG_IDX_ADDR  = 8'h70;
  localparam logic [7:0] REG_IDX_DATA  = 8'h78;

  localparam int NUM_DESC_REGS = 12;

  typedef enum logic [7:0] {
    CMD_NOP   = 8'h00,
    CMD_SPDOT = 8'h14
  } cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_REGS,
    ST_IDX_ADDR,
    ST_IDX_DATA,
    ST_WR_CMD,
    ST_POLL,
    ST_RD_SUM,
    ST_RESP
  } host_state_e;

  typedef struct packed {
    logic [63:0] q_base;
    logic [63:0] k_base;
    logic [63:0] v_base;
    logic [63:0] o_base;
    logic [63:0] idx_base;
    logic [63:0] strd_base;
    logic [31:0] m_rows;
    logic [31:0] head_d;
    logic [31:0] block_sz;
    logic [31:0] k_blocks;
    logic [31:0] s_tokens;
    logic [31:0] scale_fp;
    logic [7:0]  cmd;
    logic [15:0] idx_cnt;
  } desc_t;

  // Descriptor register slot -> byte offset, in register-map order.
  function automatic logic [7:0] desc_reg_offset(input logic [3:0] slot);
    case (slot)
      4'd0:    return REG_Q_BASE;
      4'd1:    return REG_K_BASE;
      4'd2:    return REG_V_BASE;
      4'd3:    return REG_O_BASE;
      4'd4:    return REG_IDX_BASE;
      4'd5:    return REG_STRD_BASE;
      4'd6:    return REG_M_ROWS;
      4'd7:    return REG_HEAD_D;
      4'd8:    return REG_BLOCK_SZ;
      4'd9:    return REG_K_BLOCKS;
      4'd10:   return REG_S_TOKENS;
      4'd11:   return REG_SCALE_FP;
      default: return REG_Q_BASE;
    endcase
  endfunction

endpackage

// File: rtl/sattn_mmio_host.sv
// MMIO initiator: programs one descriptor into the accelerator, optionally streams
// block indices, issues the command, polls for done, reads the checksum, responds.
module sattn_mmio_host
  import sattn_pkg::*;
#(
  parameter int ADDR_WIDTH   = 16,
  parameter int DATA_WIDTH   = 64,
  parameter int POLL_TIMEOUT = 65535
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  desc_valid,
  output logic                  desc_ready,
  input  logic [63:0]           desc_q_base,
  input  logic [63:0]           desc_k_base,
  input  logic [63:0]           desc_v_base,
  input  logic [63:0]           desc_o_base,
  input  logic [63:0]           desc_idx_base,
  input  logic [63:0]           desc_strd_base,
  input  logic [31:0]           desc_m_rows,
  input  logic [31:0]           desc_head_d,
  input  logic [31:0]           desc_block_sz,
  input  logic [31:0]           desc_k_blocks,
  input  logic [31:0]           desc_s_tokens,
  input  logic [31:0]           desc_scale_fp,
  input  logic [7:0]            desc_cmd,
  input  logic [15:0]           desc_idx_cnt,
  input  logic                  idx_valid,
  output logic                  idx_ready,
  input  logic [15:0]           idx_data,
  output logic                  mmio_wen,
  output logic                  mmio_ren,
  output logic [ADDR_WIDTH-1:0] mmio_addr,
  output logic [DATA_WIDTH-1:0] mmio_wdata,
  input  logic [DATA_WIDTH-1:0] mmio_rdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [63:0]           rsp_sum,
  output logic                  rsp_timeout,
  output logic                  busy
);

  localparam logic [15:0] POLL_LAST = 16'(POLL_TIMEOUT - 1);
  localparam logic [3:0]  REG_LAST  = 4'(NUM_DESC_REGS - 1);

  host_state_e state_q, state_d;
  logic [3:0]  reg_i_q, reg_i_d;
  logic [15:0] idx_i_q, idx_i_d;
  logic [15:0] poll_cnt_q, poll_cnt_d;
  desc_t       desc_q, desc_d;
  logic [63:0] rsp_sum_q, rsp_sum_d;
  logic        rsp_timeout_q, rsp_timeout_d;
  logic [63:0] reg_val;

  always_comb begin
    case (reg_i_q)
      4'd0:    reg_val = desc_q.q_base;
      4'd1:    reg_val = desc_q.k_base;
      4'd2:    reg_val = desc_q.v_base;
      4'd3:    reg_val = desc_q.o_base;
      4'd4:    reg_val = desc_q.idx_base;
      4'd5:    reg_val = desc_q.strd_base;
      4'd6:    reg_val = {32'h0, desc_q.m_rows};
      4'd7:    reg_val = {32'h0, desc_q.head_d};
      4'd8:    reg_val = {32'h0, desc_q.block_sz};
      4'd9:    reg_val = {32'h0, desc_q.k_blocks};
      4'd10:   reg_val = {32'h0, desc_q.s_tokens};
      4'd11:   reg_val = {32'h0, desc_q.scale_fp};
      default: reg_val = 64'h0;
    endcase
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no path infers a latch.
    state_d       = state_q;
    reg_i_d       = reg_i_q;
    idx_i_d       = idx_i_q;
    poll_cnt_d    = poll_cnt_q;
    desc_d        = desc_q;
    rsp_sum_d     = rsp_sum_q;
    rsp_timeout_d = rsp_timeout_q;
    mmio_wen      = 1'b0;
    mmio_ren      = 1'b0;
    mmio_addr     = '0;
    mmio_wdata    = '0;
    idx_ready     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (desc_valid) begin
          desc_d = '{q_base: desc_q_base, k_base: desc_k_base, v_base: desc_v_base,
                     o_base: desc_o_base, idx_base: desc_idx_base, strd_base: desc_strd_base,
                     m_rows: desc_m_rows, head_d: desc_head_d, block_sz: desc_block_sz,
                     k_blocks: desc_k_blocks, s_tokens: desc_s_tokens, scale_fp: desc_scale_fp,
                     cmd: desc_cmd, idx_cnt: desc_idx_cnt};
          reg_i_d = 4'd0;
          state_d = ST_WR_REGS;
        end
      end

      ST_WR_REGS: begin
        mmio_wen   = 1'b1;
        mmio_addr  = ADDR_WIDTH'(desc_reg_offset(reg_i_q));
        mmio_wdata = DATA_WIDTH'(reg_val);
        if (reg_i_q == REG_LAST) begin
          if (desc_q.idx_cnt != 16'd0) begin
            idx_i_d = 16'd0;
            state_d = ST_IDX_ADDR;
          end else begin
            state_d = ST_WR_CMD;
          end
        end else begin
          reg_i_d = reg_i_q + 4'd1;
        end
      end

      ST_IDX_ADDR: begin
        mmio_wen   = 1'b1;
        mmio_addr  = ADDR_WIDTH'(REG_IDX_ADDR);
        mmio_wdata = DATA_WIDTH'(idx_i_q);
        state_d    = ST_IDX_DATA;
      end

      // Strobe only on an actual transfer; an idle stream simply holds here.
      ST_IDX_DATA: begin
        idx_ready = 1'b1;
        if (idx_valid) begin
          mmio_wen   = 1'b1;
          mmio_addr  = ADDR_WIDTH'(REG_IDX_DATA);
          mmio_wdata = DATA_WIDTH'(idx_data);
          if (idx_i_q == desc_q.idx_cnt - 16'd1) begin
            state_d = ST_WR_CMD;
          end else begin
            idx_i_d = idx_i_q + 16'd1;
            state_d = ST_IDX_ADDR;
          end
        end
      end

      ST_WR_CMD: begin
        rsp_timeout_d = 1'b0;
        if (desc_q.cmd == CMD_NOP) begin
          rsp_sum_d = 64'h0;
          state_d   = ST_RESP;
        end else begin
          mmio_wen   = 1'b1;
          mmio_addr  = ADDR_WIDTH'(REG_CMD);
          mmio_wdata = DATA_WIDTH'(desc_q.cmd);
          poll_cnt_d = 16'd0;
          state_d    = ST_POLL;
        end
      end

      // Done is a single-cycle pulse, so the read strobe must be held every cycle.
      ST_POLL: begin
        mmio_ren  = 1'b1;
        mmio_addr = ADDR_WIDTH'(REG_CMD);
        if (mmio_rdata[0]) begin
          state_d = ST_RD_SUM;
        end else if (poll_cnt_q == POLL_LAST) begin
          rsp_sum_d     = 64'h0;
          rsp_timeout_d = 1'b1;
          state_d       = ST_RESP;
        end else begin
          poll_cnt_d = poll_cnt_q + 16'd1;
        end
      end

      ST_RD_SUM: begin
        mmio_ren  = 1'b1;
        mmio_addr = ADDR_WIDTH'(REG_SUM);
        rsp_sum_d = 64'(mmio_rdata);
        state_d   = ST_RESP;
      end

      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= ST_IDLE;
      reg_i_q       <= 4'd0;
      idx_i_q       <= 16'd0;
      poll_cnt_q    <= 16'd0;
      desc_q        <= '0;
      rsp_sum_q     <= 64'h0;
      rsp_timeout_q <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
      state_q       <= state_d;
      reg_i_q       <= reg_i_d;
      idx_i_q       <= idx_i_d;
      poll_cnt_q    <= poll_cnt_d;
      desc_q        <= desc_d;
      rsp_sum_q     <= rsp_sum_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign desc_ready  = (state_q == ST_IDLE);
  assign busy        = (state_q != ST_IDLE);
  assign rsp_valid   = (state_q == ST_RESP);
  assign rsp_sum     = rsp_sum_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule
